// File: rtl/icache_dm_ctrl.sv
// Direct-mapped read-only instruction cache: zero-latency hit, line refill from inst ram on miss.
// Optional ICACHE_STATS_EN adds saturating hit/miss lookup counters.
module icache_dm_ctrl #(
   parameter int LINES   = 16,
   parameter int WORDS   = 4,
   parameter int MEM_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   output logic [31:0] cpu_instr,
   output logic        cpu_hold,
   input  logic        flush,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic        mem_ce_n,
   output logic        mem_oe_n,
   output logic        mem_we_n,
   output logic        mem_bw
`ifdef ICACHE_STATS_EN
   ,output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int WB  = $clog2(WORDS);
   localparam int IB  = $clog2(LINES);
   localparam int LW  = 30 - WB;          // line address width (tag + index)
   localparam int TW  = LW - IB;
   localparam int LCW = $clog2(MEM_LAT + 1);
   localparam logic [LCW-1:0] LAT_LC  = LCW'(MEM_LAT);
   localparam logic [WB-1:0]  LAST_WC = WB'(WORDS - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t           state_q, state_d;
   logic [LINES-1:0] valid_q, valid_d;
   logic [TW-1:0]    tag_q  [LINES];
   logic [31:0]      data_q [LINES][WORDS];
   logic [LW-1:0]    miss_line_q, miss_line_d;
   logic [WB-1:0]    wc_q, wc_d;
   logic [LCW-1:0]   lc_q, lc_d;
   logic             fill_we, fill_done, hit;

   logic [TW-1:0] cpu_tag, miss_tag;
   logic [IB-1:0] cpu_idx, miss_idx;
   logic [WB-1:0] cpu_word;
   logic          unused_byte_bits;

   assign cpu_tag          = cpu_addr[31 -: TW];
   assign cpu_idx          = cpu_addr[2+WB +: IB];
   assign cpu_word         = cpu_addr[2 +: WB];
   assign miss_tag         = miss_line_q[LW-1 -: TW];
   assign miss_idx         = miss_line_q[IB-1:0];
   assign unused_byte_bits = ^cpu_addr[1:0];
   assign hit              = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign mem_we_n         = 1'b1;
   assign mem_bw           = 1'b1;

   always_comb begin
      state_d     = state_q;
      miss_line_d = miss_line_q;
      wc_d        = wc_q;
      lc_d        = lc_q;
      valid_d     = flush ? '0 : valid_q;
      fill_we     = 1'b0;
      fill_done   = 1'b0;
      cpu_hold    = 1'b0;
      cpu_instr   = '0;
      mem_ce_n    = 1'b1;
      mem_oe_n    = 1'b1;
      mem_addr    = '0;
      case (state_q)
         IDLE: begin
            if (hit) begin
               cpu_instr = data_q[cpu_idx][cpu_word];
            end else begin
               cpu_hold    = 1'b1;
               miss_line_d = cpu_addr[31:2+WB];
               wc_d        = '0;
               lc_d        = '0;
               state_d     = FILL;
            end
         end
         FILL: begin
            cpu_hold = 1'b1;
            mem_ce_n = 1'b0;
            mem_oe_n = 1'b0;
            mem_addr = {miss_line_q, wc_q, 2'b00};
            if (lc_q == LAT_LC) begin
               fill_we = 1'b1;
               lc_d    = '0;
               wc_d    = wc_q + 1'b1;
               if (wc_q == LAST_WC) begin
                  // Set after the flush clear so the just-filled line survives a coincident flush.
                  fill_done         = 1'b1;
                  valid_d[miss_idx] = 1'b1;
                  state_d           = IDLE;
               end
            end else begin
               lc_d = lc_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (reset) cpu_hold = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         miss_line_q <= '0;
         wc_q        <= '0;
         lc_q        <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         miss_line_q <= miss_line_d;
         wc_q        <= wc_d;
         lc_q        <= lc_d;
      end
   end

   // Data and tag storage carry no reset; only the valid bits qualify them.
   always_ff @(posedge clock) begin
      if (fill_we) begin
         data_q[miss_idx][wc_q] <= mem_data;
         if (fill_done) tag_q[miss_idx] <= miss_tag;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state_q == IDLE) begin
         if (hit && !(&hit_count))        hit_count  <= hit_count + 32'd1;
         else if (!hit && !(&miss_count)) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_dm_ctrl.sv
// Directed bench for icache_dm_ctrl (LINES=16, WORDS=4, MEM_LAT=1) with a one-cycle ram model.
module tb_icache_dm_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_instr;
   logic        cpu_hold;
   logic        flush;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_ce_n, mem_oe_n, mem_we_n, mem_bw;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [31:0] XORV = 32'hA5A5_0000;

   icache_dm_ctrl #(.LINES(16), .WORDS(4), .MEM_LAT(1)) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_instr (cpu_instr),
      .cpu_hold  (cpu_hold),
      .flush     (flush),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ce_n  (mem_ce_n),
      .mem_oe_n  (mem_oe_n),
      .mem_we_n  (mem_we_n),
      .mem_bw    (mem_bw)
`ifdef ICACHE_STATS_EN
      ,.hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 clock = ~clock;

   // Ram: data for the address presented in one cycle appears in the next.
   always @(posedge clock) mem_data <= mem_addr ^ XORV;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Caller has set cpu_addr on a missing address in the current cycle.
   task automatic miss_seq(input logic [31:0] addr, input int flush_at);
      logic [31:0] base;
      base = {addr[31:4], 4'h0};
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) tick();
         flush = (i == flush_at);
         #1;
         chk("miss_hold", {31'd0, cpu_hold}, 32'd1);
         if (i == 0) begin
            chk("miss_ce_idle", {31'd0, mem_ce_n}, 32'd1);
         end else begin
            chk("fill_addr", mem_addr, base + 32'((i - 1) / 2) * 32'd4);
            chk("fill_ce_oe", {30'd0, mem_ce_n, mem_oe_n}, 32'd0);
         end
      end
      tick();
      flush = 1'b0;
      #1;
      chk("relookup_hold", {31'd0, cpu_hold}, 32'd0);
      chk("relookup_instr", cpu_instr, addr ^ XORV);
   endtask

   task automatic hit_at(input logic [31:0] addr);
      tick();
      cpu_addr = addr;
      #1;
      chk("hit_hold", {31'd0, cpu_hold}, 32'd0);
      chk("hit_instr", cpu_instr, addr ^ XORV);
      chk("hit_ce", {31'd0, mem_ce_n}, 32'd1);
   endtask

   task automatic expect_miss(input logic [31:0] addr, input int flush_at);
      tick();
      cpu_addr = addr;
      miss_seq(addr, flush_at);
   endtask

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      cpu_addr = 32'h0040_0000;
      tick();
      tick();
      #1;
      chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
      chk("rst_instr", cpu_instr, 32'd0);
      chk("rst_ce_oe", {30'd0, mem_ce_n, mem_oe_n}, 32'd3);
      chk("rst_addr", mem_addr, 32'd0);
      chk("we_bw", {30'd0, mem_we_n, mem_bw}, 32'd3);

      // 1: cold miss straight out of reset
      tick();
      reset = 1'b0;
      miss_seq(32'h0040_0000, -1);

      // 2: remaining words of the line hit
      hit_at(32'h0040_0004);
      hit_at(32'h0040_0008);
      hit_at(32'h0040_000C);
`ifdef ICACHE_STATS_EN
      tick();
      #1;
      chk("stat_miss", miss_count, 32'd1);
      chk("stat_hit", hit_count, 32'd4);
`endif

      // 3: conflict eviction on index 0
      expect_miss(32'h0040_0100, -1);
      chk("conflict_instr", cpu_instr, 32'hA5E5_0100);
      expect_miss(32'h0040_0000, -1);
      chk("conflict_back", cpu_instr, 32'hA5E5_0000);

      // 4a: flush in IDLE, lookup in the flush cycle still hits
      tick();
      flush = 1'b1;
      #1;
      chk("flush_cycle_hold", {31'd0, cpu_hold}, 32'd0);
      chk("flush_cycle_instr", cpu_instr, 32'hA5E5_0000);
      tick();
      flush = 1'b0;
      miss_seq(32'h0040_0000, -1);

      // 4b: flush mid-fill clears others, keeps the line being filled
      expect_miss(32'h0040_0010, -1);
      hit_at(32'h0040_0000);
      expect_miss(32'h0040_0020, 4);
      hit_at(32'h0040_0024);
      expect_miss(32'h0040_0010, -1);

      // 4c: flush on the completion cycle
      expect_miss(32'h0040_0030, 8);
      hit_at(32'h0040_0038);
      expect_miss(32'h0040_0020, -1);

      // 5: reset during the third fill cycle
      tick();
      cpu_addr = 32'h0040_0040;
      #1;
      chk("r5_miss", {31'd0, cpu_hold}, 32'd1);
      tick();
      tick();
      tick();
      chk("r5_fill_ce", {31'd0, mem_ce_n}, 32'd0);
      reset = 1'b1;
      #1;
      chk("r5_ce_oe", {30'd0, mem_ce_n, mem_oe_n}, 32'd3);
      chk("r5_addr", mem_addr, 32'd0);
      chk("r5_hold", {31'd0, cpu_hold}, 32'd0);
      tick();
      reset = 1'b0;
      cpu_addr = 32'h0040_0030;
      miss_seq(32'h0040_0030, -1);
      expect_miss(32'h0040_0040, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
